// File: rtl/inst_prefetch.sv
// inst_prefetch: fetch PC owner, ROM driver and PC-tagged instruction FIFO with branch flush; FETCH_STALL_CNT_EN adds an empty-FIFO cycle counter
module inst_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_data_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    input  logic        id_ready_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] fetch_stall_cnt_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   pc_mem_q [DEPTH];
    logic [31:0]   inst_mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          pop, push;
    // Handshake, fetch enable and next-state; a flush clears the FIFO and retargets the PC
    always_comb begin
        if_valid_o = !rst && count_q != '0;
        pop        = if_valid_o && id_ready_i;
        push       = !rst && !branch_flag_i && (count_q != FULL || pop);
        rom_ce_o   = push;
        rom_addr_o = fetch_pc_q;
        if_pc_o    = pc_mem_q[rd_ptr_q];
        if_inst_o  = inst_mem_q[rd_ptr_q];
        fetch_pc_d = branch_flag_i ? (branch_target_i & ~32'h3) : push ? fetch_pc_q + 32'd4 : fetch_pc_q;
        rd_ptr_d   = branch_flag_i ? '0 : rd_ptr_q + AW'(pop);
        wr_ptr_d   = branch_flag_i ? '0 : wr_ptr_q + AW'(push);
        count_d    = branch_flag_i ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    // Control state; reset overrides any flush, push or pop
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end
    // Entry storage; each fetched word is tagged with the PC it was read from
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
            inst_mem_q[wr_ptr_q] <= rom_data_i;
        end
    end
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    // Count every post-reset cycle with an empty head, flush bubbles included
    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_q + 32'(!if_valid_o);
    end
    assign fetch_stall_cnt_o = rst ? 32'h0 : stall_cnt_q;
`else
    assign fetch_stall_cnt_o = 32'h0;
`endif
endmodule
